// File: rtl/wam_pkg.sv
// Shared constants for the mole-life controller: hole-select modes, LFSR tap masks
// and a constant-width helper.
package wam_pkg;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_RND = 1'b1;

  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [15:0] TAPS16 = 16'hB400;

  localparam int MAX_HOLES = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// Right-shifting Galois LFSR (W = 8 or 16), steps once per adv; ld takes priority.
// A zero seed is replaced by all ones so the register can never lock up at zero.
module wam_lfsr
  import wam_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         adv,
  input  logic         ld,
  input  logic [W-1:0] seed,
  output logic [W-1:0] num
);

  localparam logic [W-1:0] TAPS = (W == 16) ? W'(TAPS16) : W'(TAPS8);

  logic [W-1:0] r_lfsr;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_lfsr <= '1;
    end else if (ld) begin
      r_lfsr <= (seed == '0) ? '1 : seed;
    end else if (adv) begin
      r_lfsr <= (r_lfsr >> 1) ^ (r_lfsr[0] ? TAPS : '0);
    end
  end

  assign num = r_lfsr;

endmodule

// File: rtl/wam_gen_multi.sv
// Mole-life controller for N holes: tick divider, spawn/expire/hit per hole, cooldown,
// live cap; hit_ok/miss are registered one-cycle pulses, live is combinational.
module wam_gen_multi
  import wam_pkg::*;
#(
  parameter int N_HOLES  = 8,
  parameter int AGE_W    = 4,
  parameter int LFSR_W   = 8,
  parameter int TICK_DIV = 8,
  parameter int COOL     = 2,
  parameter int MAX_LIVE = 3
) (
  input  logic                           clk,
  input  logic                           clr_n,
  input  logic                           en,
  input  logic                           seed_ld,
  input  logic [LFSR_W-1:0]              seed,
  input  logic                           mode,
  input  logic [N_HOLES-1:0]             hit,
  input  logic [AGE_W-1:0]               age,
  input  logic [LFSR_W-1:0]              rto,
  output logic [N_HOLES-1:0]             holes,
  output logic [N_HOLES-1:0]             hit_ok,
  output logic [N_HOLES-1:0]             miss,
  output logic [clog2(N_HOLES+1)-1:0]    live
);

  localparam int PTR_W  = clog2(N_HOLES);
  localparam int DIV_W  = clog2(TICK_DIV);
  localparam int LIVE_W = clog2(N_HOLES + 1);
  localparam int COOL_W = (COOL < 1) ? 1 : clog2(COOL + 1);

  logic [DIV_W-1:0]  r_div;
  logic [PTR_W-1:0]  r_ptr;
  logic              w_tick;
  logic [LFSR_W-1:0] w_rnd;
  logic [PTR_W-1:0]  w_cand;
  logic              w_spawn;
  logic [N_HOLES-1:0] w_up;
  logic [N_HOLES-1:0] w_cool_z;
  logic [LIVE_W-1:0] w_live;

  // A seed load restarts the tick phase and suppresses the tick in that cycle.
  assign w_tick = en && !seed_ld && (r_div == DIV_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_div <= '0;
    end else if (seed_ld) begin
      r_div <= '0;
    end else if (en) begin
      r_div <= (r_div == DIV_W'(TICK_DIV - 1)) ? '0 : r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ptr <= '0;
    end else if (w_tick) begin
      r_ptr <= (r_ptr == PTR_W'(N_HOLES - 1)) ? '0 : r_ptr + PTR_W'(1);
    end
  end

  wam_lfsr #(.W(LFSR_W)) u_lfsr (
    .clk   (clk),
    .clr_n (clr_n),
    .adv   (w_tick),
    .ld    (seed_ld),
    .seed  (seed),
    .num   (w_rnd)
  );

  assign w_cand = (mode == MODE_RR) ? r_ptr
                                    : PTR_W'(32'(w_rnd[3:0]) % N_HOLES);

  always_comb begin
    w_live = '0;
    for (int i = 0; i < N_HOLES; i++) begin
      w_live = w_live + LIVE_W'(w_up[i]);
    end
  end

  // Every condition uses pre-tick state, so a slot freed by expiry is reusable next tick.
  assign w_spawn = w_tick && (w_rnd < rto) && !w_up[w_cand] && w_cool_z[w_cand]
                   && !hit[w_cand] && (w_live < LIVE_W'(MAX_LIVE));

  for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_hole
    logic [AGE_W-1:0]  r_cnt;
    logic [COOL_W-1:0] r_cool;
    logic              r_up;
    logic              r_hit_ok;
    logic              r_miss;
    logic              w_hit;
    logic              w_exp;
    logic              w_new;

    assign w_hit = hit[gi] && r_up;
    // >= rather than == so lowering age under a live mole still retires it.
    assign w_exp = w_tick && r_up && !w_hit && (r_cnt >= age);
    assign w_new = w_spawn && (w_cand == PTR_W'(gi));

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        r_up     <= 1'b0;
        r_cnt    <= '0;
        r_cool   <= '0;
        r_hit_ok <= 1'b0;
        r_miss   <= 1'b0;
      end else begin
        r_hit_ok <= w_hit;
        r_miss   <= w_exp;
        if (w_hit || w_exp) begin
          r_up   <= 1'b0;
          r_cnt  <= '0;
          r_cool <= COOL_W'(COOL);
        end else begin
          if (w_tick && r_up) r_cnt <= r_cnt + AGE_W'(1);
          if (w_tick && (r_cool != '0)) r_cool <= r_cool - COOL_W'(1);
          if (w_new) begin
            r_up  <= 1'b1;
            r_cnt <= '0;
          end
        end
      end
    end

    assign w_up[gi]     = r_up;
    assign w_cool_z[gi] = (r_cool == '0);
    assign hit_ok[gi]   = r_hit_ok;
    assign miss[gi]     = r_miss;
  end

  assign holes = w_up;
  assign live  = w_live;

endmodule
